// File: rtl/msg_pkg.sv
// Shared types and constants for the message deframer: FSM states, error codes
// and the header width.
package msg_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_SHORT        = 3'd1,
    ERR_LONG         = 3'd2,
    ERR_ZERO_LEN     = 3'd3,
    ERR_RUNT         = 3'd4,
    ERR_SOP_IN_FRAME = 3'd5,
    ERR_STRAY        = 3'd6
  } err_code_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/message_deframer.sv
// Strips the length header from each incoming frame, regenerates sop/eop from
// the header, flags header/eop disagreements and keeps frame/error statistics.
module message_deframer
  import msg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic             din_vld,
  output logic [7:0]       dout,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic             dout_vld,
  output logic [7:0]       dout_len,
  output logic             err_vld,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic             frame_done;
  logic             last;

  // Compared before the increment, so len=255 ends with cnt=255 and never wraps.
  assign last = (cnt == len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_vld   <= 1'b0;
      dout_len   <= '0;
      err_vld    <= 1'b0;
      err_code   <= ERR_NONE;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; later assignments in this block override them.
      dout_vld   <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      err_vld    <= 1'b0;
      frame_done <= 1'b0;

      if (din_vld) begin
        if (state == PAYLOAD) begin
          dout     <= din;
          dout_vld <= 1'b1;
          dout_sop <= (cnt == '0);
          cnt      <= cnt + LEN_W'(1);

          if (din_eop || last) begin
            dout_eop <= 1'b1;
            state    <= din_eop ? IDLE : DROP;
          end
          frame_done <= din_eop && last;

          // Only one code per cycle: SHORT beats LONG beats SOP_IN_FRAME.
          if (din_eop && !last) begin
            err_vld  <= 1'b1;
            err_code <= ERR_SHORT;
          end else if (!din_eop && last) begin
            err_vld  <= 1'b1;
            err_code <= ERR_LONG;
          end else if (din_sop) begin
            err_vld  <= 1'b1;
            err_code <= ERR_SOP_IN_FRAME;
          end
        end else if (din_sop && ((state == IDLE) || !din_eop)) begin
          // Header byte, either from IDLE or a fresh frame cutting a DROP short.
          if (din_eop) begin
            err_vld  <= 1'b1;
            err_code <= ERR_RUNT;
            state    <= IDLE;
          end else if (din == '0) begin
            err_vld  <= 1'b1;
            err_code <= ERR_ZERO_LEN;
            state    <= DROP;
          end else begin
            len      <= din;
            cnt      <= '0;
            dout_len <= din;
            state    <= PAYLOAD;
          end
        end else if (state == IDLE) begin
          err_vld  <= 1'b1;
          err_code <= ERR_STRAY;
        end else if (din_eop) begin
          state <= IDLE;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_done),
    .cnt (frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_vld),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_message_deframer.sv
// Scoreboard bench for message_deframer: frame-level reference model feeds
// expected-output queues that a negedge monitor drains.
module tb_message_deframer;
  import msg_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       din;
  logic             din_sop, din_eop, din_vld;
  logic [7:0]       dout;
  logic             dout_sop, dout_eop, dout_vld;
  logic [7:0]       dout_len;
  logic             err_vld;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] frame_cnt, err_cnt;

  message_deframer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_sop   (din_sop),
    .din_eop   (din_eop),
    .din_vld   (din_vld),
    .dout      (dout),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .dout_vld  (dout_vld),
    .dout_len  (dout_len),
    .err_vld   (err_vld),
    .err_code  (err_code),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [7:0] len;
  } exp_byte_t;

  exp_byte_t  dq[$];
  logic [2:0] eq[$];
  int         good_frames = 0;
  int         err_events  = 0;
  int         pass_cnt    = 0;
  int         total_cnt   = 0;
  bit         mon_en      = 1'b1;

  logic [7:0] pl_d[300];
  bit         pl_s[300];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or an error.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_vld) begin
        if (dq.size() == 0) begin
          check("unexpected_byte", {dout, dout_sop, dout_eop}, 64'hDEAD);
        end else begin
          exp_byte_t e;
          e = dq.pop_front();
          check("dout", {dout, dout_sop, dout_eop, dout_len}, {e.d, e.sop, e.eop, e.len});
        end
      end else if (dout_sop || dout_eop) begin
        check("flags_without_vld", {dout_sop, dout_eop}, 2'b00);
      end
      if (err_vld) begin
        if (eq.size() == 0) check("unexpected_err", {5'd0, err_code}, 8'hEE);
        else check("err_code", err_code, eq.pop_front());
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input bit s, input bit e, input bit gap);
    if (gap) repeat ($urandom_range(0, 2)) idle();
    din = d; din_sop = s; din_eop = e; din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    din     = 8'($urandom);
    din_sop = 1'($urandom);
    din_eop = 1'($urandom);
  endtask

  function automatic void push_err(input logic [2:0] code);
    eq.push_back(code);
    err_events++;
  endfunction

  // Frame with header L>0 and n payload bytes (pl_d/pl_s), eop on the last byte.
  // The first min(n,L) bytes are delivered; the remainder is dropped.
  task automatic frame(input int L, input int n);
    int k;
    k = (n < L) ? n : L;
    for (int i = 0; i < k; i++) begin
      dq.push_back('{d: pl_d[i], sop: (i == 0), eop: (i == k - 1), len: 8'(L)});
      if (i == k - 1 && n < L)      push_err(ERR_SHORT);
      else if (i == k - 1 && n > L) push_err(ERR_LONG);
      else if (pl_s[i])             push_err(ERR_SOP_IN_FRAME);
    end
    if (n == L) good_frames++;
    drive(8'(L), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) drive(pl_d[i], (i < k) ? pl_s[i] : 1'b0, i == n - 1, 1'b1);
  endtask

  task automatic fill_payload(input int n, input bit allow_sop);
    for (int i = 0; i < n; i++) begin
      pl_d[i] = 8'($urandom);
      pl_s[i] = allow_sop && ($urandom_range(0, 5) == 0);
    end
  endtask

  // Zero-length header; m dropped bytes, ending on eop unless a new header follows.
  task automatic zero_len(input int m, input bit reheader);
    push_err(ERR_ZERO_LEN);
    drive(8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < m; i++) drive(8'($urandom), 1'b0, !reheader && (i == m - 1), 1'b1);
  endtask

  task automatic check_counters(input string name);
    repeat (3) idle();
    check({name, "_frame_cnt"}, frame_cnt, CNT_W'(good_frames));
    check({name, "_err_cnt"}, err_cnt, CNT_W'(err_events));
    check({name, "_q_empty"}, {dq.size() == 0, eq.size() == 0}, 2'b11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) idle();
    rst = 1'b0;
    good_frames = 0;
    err_events  = 0;
  endtask

  initial begin
    int L, n, r;
    din = '0; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b0; rst = 1'b1;
    #1;
    do_reset();
    check("reset_outputs",
          {dout, dout_sop, dout_eop, dout_vld, dout_len, err_vld, err_code, frame_cnt, err_cnt}, '0);

    // Good frame: header 3, AA BB CC.
    pl_d[0] = 8'hAA; pl_d[1] = 8'hBB; pl_d[2] = 8'hCC;
    pl_s[0] = 0; pl_s[1] = 0; pl_s[2] = 0;
    frame(3, 3);
    check_counters("good");

    // Short frame: header 4, 11 22.
    pl_d[0] = 8'h11; pl_d[1] = 8'h22;
    frame(4, 2);
    check_counters("short");

    // Long frame: header 2, 01 02 03 04, then back-to-back header 1 + 55.
    pl_d[0] = 8'h01; pl_d[1] = 8'h02; pl_d[2] = 8'h03; pl_d[3] = 8'h04;
    frame(2, 4);
    pl_d[0] = 8'h55;
    frame(1, 1);
    check_counters("long");

    // Degenerate headers.
    zero_len(2, 1'b0);
    push_err(ERR_RUNT);
    drive(8'h07, 1'b1, 1'b1, 1'b1);
    check_counters("degenerate");

    // Stray bytes and inner sop.
    push_err(ERR_STRAY); drive(8'h12, 1'b0, 1'b0, 1'b0);
    push_err(ERR_STRAY); drive(8'h34, 1'b0, 1'b0, 1'b0);
    pl_d[0] = 8'h66; pl_s[0] = 1; pl_d[1] = 8'h77; pl_s[1] = 0;
    frame(2, 2);
    check_counters("stray_sop");

    // Header arriving while dropping is accepted straight away.
    zero_len(2, 1'b1);
    fill_payload(3, 1'b0);
    frame(3, 3);
    check_counters("drop_reheader");

    // Reset mid-payload: header 5 and two bytes, then reset.
    pl_d[0] = 8'hA1; pl_d[1] = 8'hA2;
    dq.push_back('{d: 8'hA1, sop: 1'b1, eop: 1'b0, len: 8'd5});
    dq.push_back('{d: 8'hA2, sop: 1'b0, eop: 1'b0, len: 8'd5});
    drive(8'd5, 1'b1, 1'b0, 1'b0);
    drive(pl_d[0], 1'b0, 1'b0, 1'b0);
    drive(pl_d[1], 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle();
    check("midframe_reset_outputs",
          {dout, dout_sop, dout_eop, dout_vld, dout_len, err_vld, err_code, frame_cnt, err_cnt}, '0);
    rst = 1'b0;
    good_frames = 0;
    err_events  = 0;
    push_err(ERR_STRAY);
    drive(8'h99, 1'b0, 1'b1, 1'b0);
    check_counters("post_reset");

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        L = $urandom_range(1, 10);
        case ($urandom_range(0, 3))
          0:       n = (L > 1) ? $urandom_range(1, L - 1) : L;
          1:       n = L + $urandom_range(1, 3);
          default: n = L;
        endcase
        fill_payload(n, 1'b1);
        frame(L, n);
      end else if (r < 14) begin
        zero_len($urandom_range(1, 3), 1'b0);
      end else if (r < 16) begin
        zero_len($urandom_range(0, 2), 1'b1);
        L = $urandom_range(1, 6);
        fill_payload(L, 1'b1);
        frame(L, L);
      end else if (r == 16) begin
        push_err(ERR_RUNT);
        drive(8'($urandom), 1'b1, 1'b1, 1'b1);
      end else if (r == 17) begin
        push_err(ERR_STRAY);
        drive(8'($urandom), 1'b0, 1'($urandom), 1'b1);
      end else begin
        n = 255 + $urandom_range(0, 2) - (($urandom_range(0, 1) == 1) ? 2 : 0);
        fill_payload(n, 1'b1);
        frame(255, n);
      end
    end
    check_counters("random");

    // Saturation: 2^CNT_W + 1 stray bytes.
    do_reset();
    mon_en = 1'b0;
    din = 8'h3C; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b1;
    repeat ((1 << CNT_W) + 1) @(posedge clk);
    #1;
    din_vld = 1'b0;
    repeat (3) idle();
    check("err_cnt_saturated", err_cnt, {CNT_W{1'b1}});
    check("frame_cnt_after_sat", frame_cnt, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
